// File: rtl/alu_exc_monitor.sv
// alu_exc_monitor
//   Consumes the execute-stage ALU result/status interface. Keeps registered
//   zero/negative/carry flags for branch resolution and turns qualified fault
//   bits into a prioritised exception request held through a req/ack
//   handshake with the exception/stall controller.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   valid_in             ALU output belongs to a real instruction
//   control_in[3:0]      ALU control code (2 add, 6 sub, 5 mul, 4 div)
//   mem_access_in        operation is a load/store address computation
//   status_in[7:0]       {zero, mul_ovf, carry, neg, misaligned, div0, rsvd[1:0]}
//   result_in[31:0]      ALU result (captured as bad address)
//   pc_in[31:0]          PC of the instruction
//   exc_ack              controller accepts the pending exception
//   zf, nf, cf           registered condition flags
//   exc_req              exception pending
//   exc_cause[2:0]       0 none, 1 div-by-zero, 2 mul overflow, 3 misaligned
//   exc_epc[31:0]        PC of faulting instruction
//   exc_badaddr[31:0]    result_in at fault
//   exc_missed           sticky: an event was dropped while busy
//   stall                high whenever not idle
//   exc_count            saturating count of accepted exceptions
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no exception outstanding, qualified events are accepted
// REQ    | exception presented, waiting for exc_ack
// DRAIN  | one-cycle gap after ack before the next event can be taken
module alu_exc_monitor #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid_in,
   input  logic [3:0]           control_in,
   input  logic                 mem_access_in,
   input  logic [7:0]           status_in,
   input  logic [31:0]          result_in,
   input  logic [31:0]          pc_in,
   input  logic                 exc_ack,
   output logic                 zf,
   output logic                 nf,
   output logic                 cf,
   output logic                 exc_req,
   output logic [2:0]           exc_cause,
   output logic [31:0]          exc_epc,
   output logic [31:0]          exc_badaddr,
   output logic                 exc_missed,
   output logic                 stall,
   output logic [CNT_WIDTH-1:0] exc_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_zf, r_nf, r_cf;
   logic [2:0]           r_cause;
   logic [31:0]          r_epc;
   logic [31:0]          r_badaddr;
   logic                 r_missed;
   logic [CNT_WIDTH-1:0] r_count;

   logic                 w_div, w_mul, w_mis, w_event;
   logic [2:0]           w_cause;
   logic                 w_accept;
   logic                 w_unused;

   // Fault bits only count when the control code says the fault is possible.
   assign w_div   = valid_in & status_in[2] & (control_in == 4'd4);
   assign w_mul   = valid_in & status_in[6] & (control_in == 4'd5);
   assign w_mis   = valid_in & status_in[3] & (control_in == 4'd2) & mem_access_in;
   assign w_event = w_div | w_mul | w_mis;
   assign w_cause = w_div ? 3'd1 : (w_mul ? 3'd2 : (w_mis ? 3'd3 : 3'd0));
   assign w_accept = w_event & (r_state == S_IDLE);

   assign w_unused = &{1'b0, status_in[1:0]};

   // state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_event) w_state_nxt = S_REQ;
         S_REQ:   if (exc_ack) w_state_nxt = S_DRAIN;
         S_DRAIN: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // outputs decoded from registered state only
   always_comb begin
      exc_req   = 1'b0;
      exc_cause = 3'd0;
      stall     = 1'b1;
      case (r_state)
         S_IDLE:  stall = 1'b0;
         S_REQ: begin
            exc_req   = 1'b1;
            exc_cause = r_cause;
         end
         default: ;
      endcase
   end

   // flags, exception payload, missed flag and counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_zf      <= 1'b0;
         r_nf      <= 1'b0;
         r_cf      <= 1'b0;
         r_cause   <= 3'd0;
         r_epc     <= 32'd0;
         r_badaddr <= 32'd0;
         r_missed  <= 1'b0;
         r_count   <= '0;
      end else begin
         if (valid_in) begin
            r_zf <= status_in[7];
            r_nf <= status_in[4];
            r_cf <= status_in[5];
         end
         if (w_accept) begin
            r_cause   <= w_cause;
            r_epc     <= pc_in;
            r_badaddr <= result_in;
            if (r_count != {CNT_WIDTH{1'b1}})
               r_count <= r_count + CNT_WIDTH'(1);
         end
         // A drop on the ack edge must survive the clear.
         if (w_event && (r_state != S_IDLE))
            r_missed <= 1'b1;
         else if ((r_state == S_REQ) && exc_ack)
            r_missed <= 1'b0;
      end
   end

   assign zf          = r_zf;
   assign nf          = r_nf;
   assign cf          = r_cf;
   assign exc_epc     = r_epc;
   assign exc_badaddr = r_badaddr;
   assign exc_missed  = r_missed;
   assign exc_count   = r_count;

endmodule

// File: tb/tb_alu_exc_monitor.sv
module tb_alu_exc_monitor;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          valid_in;
   logic [3:0]    control_in;
   logic          mem_access_in;
   logic [7:0]    status_in;
   logic [31:0]   result_in;
   logic [31:0]   pc_in;
   logic          exc_ack;
   logic          zf, nf, cf, exc_req, exc_missed, stall;
   logic [2:0]    exc_cause;
   logic [31:0]   exc_epc, exc_badaddr;
   logic [CW-1:0] exc_count;

   int n_chk  = 0;
   int n_fail = 0;

   alu_exc_monitor #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .control_in(control_in),
      .mem_access_in(mem_access_in), .status_in(status_in), .result_in(result_in),
      .pc_in(pc_in), .exc_ack(exc_ack), .zf(zf), .nf(nf), .cf(cf),
      .exc_req(exc_req), .exc_cause(exc_cause), .exc_epc(exc_epc),
      .exc_badaddr(exc_badaddr), .exc_missed(exc_missed), .stall(stall),
      .exc_count(exc_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic          zf, nf, cf, req;
      logic [2:0]    cause;
      logic [31:0]   epc, bad;
      logic          missed, stall;
      logic [CW-1:0] count;
   } exp_t;

   exp_t exp_q[$];

   // phase: 0 nothing outstanding, 1 waiting for ack, 2 one cycle after ack
   int          m_phase = 0;
   logic        m_zf = 0, m_nf = 0, m_cf = 0, m_missed = 0;
   logic [2:0]  m_cause = 0;
   logic [31:0] m_epc = 0, m_bad = 0;
   int          m_count = 0;

   always @(posedge clk) begin
      int   c;
      exp_t e;
      if (reset) begin
         m_phase = 0; m_zf = 0; m_nf = 0; m_cf = 0; m_missed = 0;
         m_cause = 0; m_epc = 0; m_bad = 0; m_count = 0;
      end else begin
         c = 0;
         if (valid_in) begin
            m_zf = status_in[7]; m_nf = status_in[4]; m_cf = status_in[5];
            if (status_in[2] && control_in == 4)                      c = 1;
            else if (status_in[6] && control_in == 5)                 c = 2;
            else if (status_in[3] && control_in == 2 && mem_access_in) c = 3;
         end
         if (m_phase == 0) begin
            if (c != 0) begin
               m_phase = 1; m_cause = 3'(c); m_epc = pc_in; m_bad = result_in;
               if (m_count < (1 << CW) - 1) m_count++;
            end
         end else if (m_phase == 1) begin
            if (c != 0)       m_missed = 1;
            else if (exc_ack) m_missed = 0;
            if (exc_ack) m_phase = 2;
         end else begin
            if (c != 0) m_missed = 1;
            m_phase = 0;
         end
      end
      e.zf = m_zf; e.nf = m_nf; e.cf = m_cf;
      e.req = (m_phase == 1);
      e.cause = (m_phase == 1) ? m_cause : 3'd0;
      e.epc = m_epc; e.bad = m_bad; e.missed = m_missed;
      e.stall = (m_phase != 0);
      e.count = CW'(m_count);
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_zf",      32'(zf),          32'(e.zf));
         chk("sb_nf",      32'(nf),          32'(e.nf));
         chk("sb_cf",      32'(cf),          32'(e.cf));
         chk("sb_req",     32'(exc_req),     32'(e.req));
         chk("sb_cause",   32'(exc_cause),   32'(e.cause));
         chk("sb_epc",     exc_epc,          e.epc);
         chk("sb_badaddr", exc_badaddr,      e.bad);
         chk("sb_missed",  32'(exc_missed),  32'(e.missed));
         chk("sb_stall",   32'(stall),       32'(e.stall));
         chk("sb_count",   32'(exc_count),   32'(e.count));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] ctl, input logic mem,
                        input logic [7:0] st, input logic [31:0] res, input logic [31:0] pc);
      valid_in = v; control_in = ctl; mem_access_in = mem;
      status_in = st; result_in = res; pc_in = pc;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 1'b0, 8'h00, 32'd0, 32'd0);
   endtask

   initial begin
      reset = 1'b1; exc_ack = 1'b0;
      drive(1'b1, 4'd4, 1'b1, 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step(); step();
      chk("rst_req",   32'(exc_req),   0);
      chk("rst_stall", 32'(stall),     0);
      chk("rst_zf",    32'(zf),        0);
      chk("rst_count", 32'(exc_count), 0);
      reset = 1'b0; idle();
      step();

      // div-by-zero accepted, then held without ack
      drive(1'b1, 4'd4, 1'b0, 8'h84, 32'h0, 32'h0040_0010);
      step();
      chk("div_req",   32'(exc_req),   1);
      chk("div_cause", 32'(exc_cause), 1);
      chk("div_epc",   exc_epc,        32'h0040_0010);
      chk("div_zf",    32'(zf),        1);
      chk("div_count", 32'(exc_count), 1);
      idle();
      repeat (5) step();
      chk("hold_cause", 32'(exc_cause), 1);

      // mul overflow while busy is dropped
      drive(1'b1, 4'd5, 1'b0, 8'h40, 32'h55, 32'h0040_0020);
      step();
      chk("drop_missed", 32'(exc_missed), 1);
      chk("drop_epc",    exc_epc,         32'h0040_0010);
      chk("drop_count",  32'(exc_count),  1);
      idle(); exc_ack = 1'b1;
      step();
      exc_ack = 1'b0;
      chk("ack_req",    32'(exc_req),    0);
      chk("ack_stall",  32'(stall),      1);
      chk("ack_missed", 32'(exc_missed), 0);
      step();
      chk("drain_stall", 32'(stall), 0);

      // misaligned address
      drive(1'b1, 4'd2, 1'b1, 8'h0C, 32'h1002, 32'h0040_0030);
      step();
      chk("mis_cause", 32'(exc_cause), 3);
      chk("mis_bad",   exc_badaddr,    32'h1002);
      // ack edge coincides with a new event: missed stays set
      drive(1'b1, 4'd5, 1'b0, 8'h40, 32'h0, 32'h0040_0040);
      exc_ack = 1'b1;
      step();
      exc_ack = 1'b0; idle();
      chk("ackev_missed", 32'(exc_missed), 1);
      step();
      // same status without memory access: flags only
      drive(1'b1, 4'd2, 1'b0, 8'hBC, 32'h1002, 32'h0040_0050);
      step();
      chk("nomem_req", 32'(exc_req), 0);
      chk("nomem_nf",  32'(nf),      1);
      chk("nomem_cf",  32'(cf),      1);
      idle();

      // counter saturation (count is 2 here)
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'd4, 1'b0, 8'h04, 32'(i), 32'h100 + 32'(i));
         step();
         chk("sat_count", 32'(exc_count), 3);
         idle(); exc_ack = 1'b1;
         step();
         exc_ack = 1'b0;
         step();
      end

      // reset in the middle of a handshake
      drive(1'b1, 4'd5, 1'b0, 8'h40, 32'h0, 32'h0040_0060);
      step();
      idle(); reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mrst_req",   32'(exc_req),   0);
      chk("mrst_stall", 32'(stall),     0);
      chk("mrst_cause", 32'(exc_cause), 0);
      drive(1'b1, 4'd4, 1'b0, 8'h04, 32'h0, 32'h0040_0070);
      step();
      chk("post_req",   32'(exc_req),   1);
      chk("post_count", 32'(exc_count), 1);
      idle();

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [7:0] s;
         logic [3:0] ctl;
         s = 8'($urandom);
         if ($urandom_range(0, 2) != 0) s = s & 8'hB3;
         case ($urandom_range(0, 4))
            0: ctl = 4'd2;
            1: ctl = 4'd4;
            2: ctl = 4'd5;
            3: ctl = 4'd6;
            default: ctl = 4'($urandom);
         endcase
         drive(($urandom_range(0, 3) != 0), ctl, 1'($urandom), s, $urandom, $urandom);
         exc_ack = ($urandom_range(0, 9) < 4);
         reset   = ($urandom_range(0, 49) == 0);
         step();
      end
      reset = 1'b0; exc_ack = 1'b0; idle();
      repeat (3) step();
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
